// File: rtl/cla8_serial_adder.sv
// Multi-cycle NBYTES*8-bit adder/subtractor. One byte per cycle, LSB first,
// goes through a single 8-bit carry-lookahead slice; the slice carry is registered between bytes.
module cla8_serial_adder #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic [7:0]      w_g;
    logic [7:0]      w_p;
    logic [8:0]      w_c;
    logic [7:0]      w_s;
    logic            w_term;
    logic            w_accept;
    logic            w_last;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_idx == LAST);

    // Operands are shifted right each cycle, so the current byte is always [7:0].
    always_comb begin
        w_g    = r_a[7:0] & r_b[7:0];
        w_p    = r_a[7:0] ^ r_b[7:0];
        w_c    = '0;
        w_term = 1'b0;
        w_c[0] = r_carry;
        for (int unsigned i = 0; i < 8; i++) begin
            w_term = r_carry;
            for (int unsigned k = 0; k <= i; k++) begin
                w_term = w_term & w_p[k];
            end
            w_c[i+1] = w_term;
            for (int unsigned j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_c[i+1] = w_c[i+1] | w_term;
            end
        end
        w_s = w_p ^ w_c[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b ^ {W{sub}};
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            // Constant-index byte writes leave unprocessed bytes untouched.
            for (int unsigned n = 0; n < NBYTES; n++) begin
                if (r_idx == IW'(n)) begin
                    r_sum[8*n +: 8] <= w_s;
                end
            end
            r_a     <= r_a >> 8;
            r_b     <= r_b >> 8;
            r_carry <= w_c[8];
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_c[8];
                r_ovf  <= w_c[8] ^ w_c[7];
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla8_serial_adder.sv
// Directed bench for cla8_serial_adder: a 4-byte and a 1-byte instance,
// with hand-computed results checked at the done pulse.
module tb_cla8_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        start4, cin4, sub4;
    logic [31:0] a4, b4;
    logic        busy4, done4, cout4, ovf4;
    logic [31:0] sum4;

    logic        start1, cin1, sub1;
    logic [7:0]  a1, b1;
    logic        busy1, done1, cout1, ovf1;
    logic [7:0]  sum1;

    int n_total;
    int n_bad;

    cla8_serial_adder #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .cin(cin4), .sub(sub4), .busy(busy4), .done(done4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    cla8_serial_adder #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input bit one,
                          input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tcin, input logic tsub,
                          input logic [31:0] es, input logic ec, input logic eo,
                          input int elat);
        int k;
        if (one) begin
            a1 = ta[7:0]; b1 = tb_[7:0]; cin1 = tcin; sub1 = tsub; start1 = 1'b1;
        end else begin
            a4 = ta; b4 = tb_; cin4 = tcin; sub4 = tsub; start4 = 1'b1;
        end
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        a1 = '0; b1 = '0; a4 = '1; b4 = '1;
        check({tag, "_busy"}, one ? busy1 : busy4, 1'b1);
        k = 0;
        while (k < 12 && !(one ? done1 : done4)) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, k, elat);
        check({tag, "_sum"}, one ? {24'h0, sum1} : sum4, es);
        check({tag, "_cout"}, one ? cout1 : cout4, ec);
        check({tag, "_ovf"}, one ? ovf1 : ovf4, eo);
        @(posedge clk); #1;
        check({tag, "_donedrop"}, one ? {done1, busy1} : {done4, busy4}, 2'b00);
        check({tag, "_hold"}, one ? {24'h0, sum1} : sum4, es);
    endtask

    initial begin
        int dones;
        n_total = 0;
        n_bad   = 0;
        rst_n  = 1'b0;
        start4 = 0; cin4 = 0; sub4 = 0; a4 = '0; b4 = '0;
        start1 = 0; cin1 = 0; sub1 = 0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst4", {busy4, done4, cout4, ovf4}, 4'b0);
        check("rst4_sum", sum4, 32'h0);
        check("rst1", {busy1, done1, cout1, ovf1, sum1}, 12'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1", 0, 32'hFFFFFFFA, 32'h00000006, 0, 0, 32'h00000000, 1, 0, 4);
        run_op("t2", 0, 32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 4);
        run_op("t3a", 0, 32'h00000007, 32'h00000005, 0, 1, 32'h00000002, 1, 0, 4);
        run_op("t3b", 0, 32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0, 4);

        // Abort mid-run: two bytes written, upper bytes still from t3b.
        a4 = 32'h11111111; b4 = 32'h11111111; cin4 = 0; sub4 = 0; start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_partial", sum4, 32'hFFFF2222);
        rst_n = 1'b0;
        #1;
        check("t6_rst", {busy4, done4, cout4, ovf4}, 4'b0);
        check("t6_rst_sum", sum4, 32'h0);
        dones = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        check("t6_nodone", dones, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("t6_new", 0, 32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0, 4);

        run_op("tcin", 0, 32'h00000001, 32'h00000002, 1, 0, 32'h00000004, 0, 0, 4);

        // start held through the run with churning operands.
        a4 = 32'hFFFFFFFF; b4 = 32'h0; cin4 = 1; sub4 = 0; start4 = 1;
        @(posedge clk); #1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            a4 = $urandom; b4 = $urandom; cin4 = 0; sub4 = 1;
            if (done4) begin
                dones++;
                check("t4_sum", sum4, 32'h0);
                check("t4_cout", cout4, 1'b1);
                start4 = 0;
            end
            @(posedge clk); #1;
        end
        start4 = 0;
        check("t4_ndone", dones, 1);

        run_op("t5a", 1, 32'hFA, 32'hF0, 0, 0, 32'hEA, 1, 0, 1);
        run_op("t5b", 1, 32'h38, 32'h90, 0, 0, 32'hC8, 0, 0, 1);

        // Back-to-back: start presented in the IDLE cycle right after done.
        run_op("bb1", 0, 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0, 4);
        run_op("bb2", 0, 32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
